// File: rtl/sa_result_drain.sv
// Drain stage behind the systolic-array core: captures one batch of column results,
// requantizes it (rounding shift + saturation) and streams it out over valid/ready.
module sa_result_drain #(
  parameter int ROWS     = 8,
  parameter int INWIDTH  = 32,
  parameter int OUTWIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [INWIDTH-1:0]        in_r [0:ROWS-1],
  input  logic [0:ROWS-1]           in_v,
  output logic                      in_read,
  input  logic [4:0]                shamt,
  input  logic                      clr_sat,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [OUTWIDTH-1:0]       m_data,
  output logic [$clog2(ROWS)-1:0]   m_idx,
  output logic                      m_last,
  output logic                      sat_flag
);

  localparam int IW = $clog2(ROWS);
  localparam logic [IW-1:0] LAST_IDX = IW'(ROWS - 1);
  localparam logic signed [INWIDTH:0] MAX_V = (INWIDTH+1)'((2 ** (OUTWIDTH - 1)) - 1);
  localparam logic signed [INWIDTH:0] MIN_V = -MAX_V - 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state, state_next;
  logic [IW-1:0]       idx, idx_next;
  logic                armed;
  logic                capture;
  logic [OUTWIDTH-1:0] qbuf [0:ROWS-1];
  logic [OUTWIDTH-1:0] qval [0:ROWS-1];
  logic [ROWS-1:0]     clip;

  // Returns {clipped, value}; one extra bit of headroom keeps the rounding add from wrapping.
  function automatic logic [OUTWIDTH:0] quantize(input logic [INWIDTH-1:0] v,
                                                 input logic [4:0] sh);
    logic signed [INWIDTH:0] rnd;
    logic signed [INWIDTH:0] t;
    logic signed [INWIDTH:0] s;
    rnd = '0;
    if (sh != 5'd0) rnd = (INWIDTH+1)'(1) << (sh - 5'd1);
    t = $signed({v[INWIDTH-1], v}) + rnd;
    s = t >>> sh;
    if (s > MAX_V) return {1'b1, MAX_V[OUTWIDTH-1:0]};
    if (s < MIN_V) return {1'b1, MIN_V[OUTWIDTH-1:0]};
    return {1'b0, s[OUTWIDTH-1:0]};
  endfunction

  always_comb begin
    clip = '0;
    qval = '{default: '0};
    for (int i = 0; i < ROWS; i++) {clip[i], qval[i]} = quantize(in_r[i], shamt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Stream outputs are forced to zero outside SEND so reset and idle look identical.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    capture    = 1'b0;
    m_valid    = 1'b0;
    m_data     = '0;
    m_idx      = '0;
    m_last     = 1'b0;
    case (state)
      IDLE: begin
        if (armed && (&in_v)) begin
          capture    = 1'b1;
          idx_next   = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        m_valid = 1'b1;
        m_data  = qbuf[idx];
        m_idx   = idx;
        m_last  = (idx == LAST_IDX);
        if (m_ready) begin
          if (idx == LAST_IDX) state_next = IDLE;
          else                 idx_next   = idx + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // armed blocks a second capture of the same core results until some in_v bit drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_read  <= 1'b0;
      armed    <= 1'b1;
      sat_flag <= 1'b0;
      for (int i = 0; i < ROWS; i++) qbuf[i] <= '0;
    end else begin
      in_read <= capture;
      if (capture)       armed <= 1'b0;
      else if (!(&in_v)) armed <= 1'b1;
      if (capture && (|clip)) sat_flag <= 1'b1;
      else if (clr_sat)       sat_flag <= 1'b0;
      if (capture) begin
        for (int i = 0; i < ROWS; i++) qbuf[i] <= qval[i];
      end
    end
  end

endmodule
